pu_or1k_pic_prio: RTL and testbench

// - Next-generation OR1K programmable interrupt controller: NUM_IRQ lines, per-line edge/level mode
//   set at run time via new SPR PICTR, input synchronisers, registered highest-priority request.
// - Request is (irq_o, irq_id_o) with an ack handshake.
// - Sits in core/control beside the SPR bus. Drives the exception unit and exports PICMR/PICSR.

---
 rtl/pu_or1k_pic_pkg.sv | 26 ++
 rtl/pu_or1k_pic_prienc.sv | 26 ++
 rtl/pu_or1k_pic_prio.sv | 180 ++++++++++++++++++
 tb/tb_pu_or1k_pic_prio.sv | 316 +++++++++++++++++++++++++++++++
 4 files changed

// File: rtl/pu_or1k_pic_pkg.sv
// Shared types and constants for the OR1K programmable interrupt controller.
// Contents: FSM state type, SPR group/offset decode constants, and a helper
// that builds a mask of the low n bits of a 32-bit word.
package pu_or1k_pic_pkg;

    typedef enum logic [1:0] {
        PIC_IDLE = 2'd0,
        PIC_REQ  = 2'd1,
        PIC_HOLD = 2'd2
    } pic_state_t;

    localparam logic [4:0]  PIC_SPR_GROUP = 5'd9;
    localparam logic [10:0] PIC_OFS_PICMR = 11'd0;
    localparam logic [10:0] PIC_OFS_PICSR = 11'd2;
    localparam logic [10:0] PIC_OFS_PICTR = 11'd3;

    function automatic logic [31:0] pic_low_mask(input int n);
        if (n >= 32)
            return '1;
        else if (n <= 0)
            return '0;
        else
            return (32'd1 << n) - 32'd1;
    endfunction

endpackage

// File: rtl/pu_or1k_pic_prienc.sv
// First-one encoder: reports whether any request bit is set and the index of
// the lowest set bit (lowest index = highest priority).
// Ports:
//   req   in   N  request vector
//   valid out  1  any bit of req set
//   idx   out  5  index of lowest set bit (0 when none)
module pu_or1k_pic_prienc #(
    parameter int N = 32
) (
    input  logic [N-1:0] req,
    output logic         valid,
    output logic [4:0]   idx
);

    // Scan from the top down so the last hit, i.e. the lowest index, sticks.
    always_comb begin
        idx = '0;
        for (int i = N - 1; i >= 0; i--) begin
            if (req[i])
                idx = 5'(i);
        end
    end

    assign valid = |req;

endmodule

// File: rtl/pu_or1k_pic_prio.sv
// OR1K programmable interrupt controller with per-line edge/level trigger
// (PICTR), input synchronisers and a registered highest-priority request with
// an ack handshake.
// Ports:
//   clk, rst                  clock, async active-high reset
//   irq_i        [NUM_IRQ]    raw interrupt lines
//   spr_access_i/we_i/addr_i/dat_i   SPR bus request
//   spr_bus_ack, spr_dat_o    SPR ack and combinational read data
//   spr_picmr_o, spr_picsr_o  exported mask / status registers
//   irq_o, irq_id_o           request to core and its line number
//   irq_ack_i                 1-cycle ack from core
//
// state    | meaning
// PIC_IDLE | no request outstanding, waiting for any PICSR bit
// PIC_REQ  | irq_o high, irq_id_o frozen until ack or withdraw
// PIC_HOLD | one dead cycle after ack so PICSR settles
module pu_or1k_pic_prio
    import pu_or1k_pic_pkg::*;
#(
    parameter int NUM_IRQ     = 32,
    parameter int NMI_WIDTH   = 0,
    parameter int SYNC_STAGES = 2,
    parameter int TRIG_RESET  = 0
) (
    input  logic               clk,
    input  logic               rst,
    input  logic [NUM_IRQ-1:0] irq_i,
    input  logic               spr_access_i,
    input  logic               spr_we_i,
    input  logic [15:0]        spr_addr_i,
    input  logic [31:0]        spr_dat_i,
    output logic               spr_bus_ack,
    output logic [31:0]        spr_dat_o,
    output logic [31:0]        spr_picmr_o,
    output logic [31:0]        spr_picsr_o,
    output logic               irq_o,
    output logic [4:0]         irq_id_o,
    input  logic               irq_ack_i
);

    localparam logic [31:0] IMPL_MASK = pic_low_mask(NUM_IRQ);
    localparam logic [31:0] NMI_MASK  = pic_low_mask(NMI_WIDTH) & IMPL_MASK;
    localparam logic [31:0] TRIG_INIT = (TRIG_RESET != 0) ? IMPL_MASK : 32'd0;

    logic [31:0] irq_w, s, u, u_q;
    logic [31:0] picmr_q, pictr_q, edge_q, edge_d, picsr;
    logic [31:0] set_vec, clr_vec, ack_vec, trig_chg;
    logic        spr_hit, wr_picmr, wr_picsr, wr_pictr, ack_take;
    logic [10:0] spr_ofs;
    logic        pri_valid;
    logic [4:0]  pri_idx;

    pic_state_t  state_q, state_d;
    logic        irq_q, irq_d;
    logic [4:0]  id_q, id_d;

    assign irq_w = 32'(irq_i);

    generate
        if (SYNC_STAGES == 0) begin : g_nosync
            assign s = irq_w;
        end else begin : g_sync
            logic [31:0] stage_q [SYNC_STAGES];
            always_ff @(posedge clk or posedge rst) begin
                if (rst) begin
                    for (int k = 0; k < SYNC_STAGES; k++)
                        stage_q[k] <= '0;
                end else begin
                    stage_q[0] <= irq_w;
                    for (int k = 1; k < SYNC_STAGES; k++)
                        stage_q[k] <= stage_q[k-1];
                end
            end
            assign s = stage_q[SYNC_STAGES-1];
        end
    endgenerate

    assign u     = s & picmr_q;
    // Level lines expose the live masked input; edge lines expose the latch.
    assign picsr = ((pictr_q & edge_q) | (~pictr_q & u)) & IMPL_MASK;

    assign spr_ofs  = spr_addr_i[10:0];
    assign spr_hit  = spr_access_i && (spr_addr_i[15:11] == PIC_SPR_GROUP);
    assign wr_picmr = spr_hit && spr_we_i && (spr_ofs == PIC_OFS_PICMR);
    assign wr_picsr = spr_hit && spr_we_i && (spr_ofs == PIC_OFS_PICSR);
    assign wr_pictr = spr_hit && spr_we_i && (spr_ofs == PIC_OFS_PICTR);
    assign ack_take = (state_q == PIC_REQ) && irq_ack_i;

    assign set_vec  = u & ~u_q & pictr_q;
    assign ack_vec  = ack_take ? (32'd1 << id_q) : 32'd0;
    assign clr_vec  = (wr_picsr ? spr_dat_i : 32'd0) | ack_vec;
    assign trig_chg = wr_pictr ? ((spr_dat_i & IMPL_MASK) ^ pictr_q) : 32'd0;
    // Set wins over clear; a trigger-mode change discards any pending edge.
    assign edge_d   = (set_vec | (edge_q & ~clr_vec)) & pictr_q & ~trig_chg & IMPL_MASK;

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            picmr_q <= NMI_MASK;
            pictr_q <= TRIG_INIT;
            edge_q  <= '0;
            u_q     <= '0;
        end else begin
            edge_q <= edge_d;
            u_q    <= u;
            if (wr_picmr)
                picmr_q <= (spr_dat_i | NMI_MASK) & IMPL_MASK;
            if (wr_pictr)
                pictr_q <= spr_dat_i & IMPL_MASK;
        end
    end

    pu_or1k_pic_prienc #(.N(NUM_IRQ)) u_prienc (
        .req   (picsr[NUM_IRQ-1:0]),
        .valid (pri_valid),
        .idx   (pri_idx)
    );

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q <= PIC_IDLE;
            irq_q   <= 1'b0;
            id_q    <= '0;
        end else begin
            state_q <= state_d;
            irq_q   <= irq_d;
            id_q    <= id_d;
        end
    end

    always_comb begin
        state_d = state_q;
        irq_d   = irq_q;
        id_d    = id_q;
        case (state_q)
            PIC_IDLE: begin
                if (pri_valid) begin
                    state_d = PIC_REQ;
                    irq_d   = 1'b1;
                    id_d    = pri_idx;
                end
            end
            PIC_REQ: begin
                if (irq_ack_i) begin
                    state_d = PIC_HOLD;
                    irq_d   = 1'b0;
                end else if (!picsr[id_q]) begin
                    state_d = PIC_IDLE;
                    irq_d   = 1'b0;
                end
            end
            PIC_HOLD: begin
                state_d = PIC_IDLE;
                irq_d   = 1'b0;
            end
            default: begin
                state_d = PIC_IDLE;
                irq_d   = 1'b0;
            end
        endcase
    end

    always_comb begin
        spr_dat_o = '0;
        if (spr_hit) begin
            case (spr_ofs)
                PIC_OFS_PICMR: spr_dat_o = picmr_q;
                PIC_OFS_PICSR: spr_dat_o = picsr;
                PIC_OFS_PICTR: spr_dat_o = pictr_q;
                default:       spr_dat_o = '0;
            endcase
        end
    end

    assign spr_bus_ack = spr_access_i;
    assign spr_picmr_o = picmr_q;
    assign spr_picsr_o = picsr;
    assign irq_o       = irq_q;
    assign irq_id_o    = id_q;

endmodule

// File: tb/tb_pu_or1k_pic_prio.sv
module tb_pu_or1k_pic_prio;

    localparam logic [15:0] A_PICMR = 16'h4800;
    localparam logic [15:0] A_OFS1  = 16'h4801;
    localparam logic [15:0] A_PICSR = 16'h4802;
    localparam logic [15:0] A_PICTR = 16'h4803;

    logic        clk = 1'b0;
    logic        rst = 1'b1;
    logic [7:0]  irq_i = '0;
    logic        spr_access_i = 1'b0;
    logic        spr_we_i = 1'b0;
    logic [15:0] spr_addr_i = '0;
    logic [31:0] spr_dat_i = '0;
    logic        irq_ack_i = 1'b0;
    logic        spr_bus_ack;
    logic [31:0] spr_dat_o, spr_picmr_o, spr_picsr_o;
    logic        irq_o;
    logic [4:0]  irq_id_o;

    int vectors = 0;
    int miscompares = 0;

    pu_or1k_pic_prio #(
        .NUM_IRQ(8), .NMI_WIDTH(2), .SYNC_STAGES(2), .TRIG_RESET(0)
    ) dut (
        .clk          (clk),
        .rst          (rst),
        .irq_i        (irq_i),
        .spr_access_i (spr_access_i),
        .spr_we_i     (spr_we_i),
        .spr_addr_i   (spr_addr_i),
        .spr_dat_i    (spr_dat_i),
        .spr_bus_ack  (spr_bus_ack),
        .spr_dat_o    (spr_dat_o),
        .spr_picmr_o  (spr_picmr_o),
        .spr_picsr_o  (spr_picsr_o),
        .irq_o        (irq_o),
        .irq_id_o     (irq_id_o),
        .irq_ack_i    (irq_ack_i)
    );

    always #5 clk = ~clk;

    // Reference model: registers as plain bytes, the synchroniser as a
    // 2-entry delay queue, the request channel as "pending / hold" flags.
    logic [7:0] m_mask, m_trig, m_pend, m_uq;
    logic [7:0] m_delay[$];
    bit         m_req, m_hold;
    int         m_id;

    function automatic logic [7:0] m_u();
        return m_delay[0] & m_mask;
    endfunction

    function automatic logic [7:0] m_picsr();
        logic [7:0] r;
        logic [7:0] uu;
        uu = m_u();
        for (int i = 0; i < 8; i++)
            r[i] = m_trig[i] ? m_pend[i] : uu[i];
        return r;
    endfunction

    function automatic logic [31:0] m_rd();
        if (!spr_access_i || spr_addr_i[15:11] != 5'd9) return 32'd0;
        case (spr_addr_i[10:0])
            11'd0:   return {24'd0, m_mask};
            11'd2:   return {24'd0, m_picsr()};
            11'd3:   return {24'd0, m_trig};
            default: return 32'd0;
        endcase
    endfunction

    task automatic m_reset();
        m_mask = 8'h03;
        m_trig = 8'h00;
        m_pend = 8'h00;
        m_uq   = 8'h00;
        m_delay = {8'h00, 8'h00};
        m_req  = 0;
        m_hold = 0;
        m_id   = 0;
    endtask

    task automatic m_update();
        logic [7:0] ps, uu;
        bit wr, acked, rise, cleared;
        ps = m_picsr();
        uu = m_u();
        wr = spr_access_i && spr_we_i && (spr_addr_i[15:11] == 5'd9);
        acked = m_req && irq_ack_i;
        for (int i = 0; i < 8; i++) begin
            rise    = m_trig[i] && uu[i] && !m_uq[i];
            cleared = (wr && spr_addr_i[10:0] == 11'd2 && spr_dat_i[i]) || (acked && m_id == i);
            if (rise) m_pend[i] = 1'b1;
            else if (cleared) m_pend[i] = 1'b0;
            if (!m_trig[i]) m_pend[i] = 1'b0;
            if (wr && spr_addr_i[10:0] == 11'd3 && spr_dat_i[i] != m_trig[i]) m_pend[i] = 1'b0;
        end
        if (m_hold) begin
            m_hold = 0;
        end else if (m_req) begin
            if (irq_ack_i) begin
                m_req = 0;
                m_hold = 1;
            end else if (!ps[m_id]) begin
                m_req = 0;
            end
        end else if (ps != 0) begin
            m_req = 1;
            for (int i = 0; i < 8; i++)
                if (ps[i]) begin m_id = i; break; end
        end
        if (wr && spr_addr_i[10:0] == 11'd0) m_mask = spr_dat_i[7:0] | 8'h03;
        if (wr && spr_addr_i[10:0] == 11'd3) m_trig = spr_dat_i[7:0];
        m_uq = uu;
        void'(m_delay.pop_front());
        m_delay.push_back(irq_i);
    endtask

    task automatic tick();
        @(posedge clk);
        m_update();
        #1;
        spr_access_i = 1'b0;
        spr_we_i     = 1'b0;
        irq_ack_i    = 1'b0;
    endtask

    task automatic spr_wr(input logic [15:0] a, input logic [31:0] d);
        spr_access_i = 1'b1;
        spr_we_i     = 1'b1;
        spr_addr_i   = a;
        spr_dat_i    = d;
        tick();
    endtask

    task automatic do_reset();
        rst = 1'b1;
        irq_i = '0;
        spr_access_i = 1'b0;
        spr_we_i = 1'b0;
        irq_ack_i = 1'b0;
        m_reset();
        repeat (2) @(posedge clk);
        #1;
        rst = 1'b0;
    endtask

    task automatic test_reset();
        do_reset();
        vectors++; if (irq_o !== 1'b0) begin miscompares++; $display("FAIL reset_irq: got %b want 0", irq_o); end
        vectors++; if (irq_id_o !== 5'd0) begin miscompares++; $display("FAIL reset_id: got %0d want 0", irq_id_o); end
        vectors++; if (spr_picsr_o !== 32'h0) begin miscompares++; $display("FAIL reset_picsr: got %h want 0", spr_picsr_o); end
        vectors++; if (spr_picmr_o !== 32'h3) begin miscompares++; $display("FAIL reset_picmr: got %h want 3", spr_picmr_o); end
        spr_access_i = 1'b1; spr_we_i = 1'b0; spr_addr_i = A_PICTR; #1;
        vectors++; if (spr_dat_o !== 32'h0) begin miscompares++; $display("FAIL reset_pictr_rd: got %h want 0", spr_dat_o); end
        vectors++; if (spr_bus_ack !== 1'b1) begin miscompares++; $display("FAIL reset_bus_ack: got %b want 1", spr_bus_ack); end
        tick();
    endtask

    task automatic test_level_basic();
        do_reset();
        spr_wr(A_PICMR, 32'hFF);
        irq_i = 8'h20;
        tick();
        vectors++; if (spr_picsr_o !== 32'h0) begin miscompares++; $display("FAIL lvl_picsr_t1: got %h want 0", spr_picsr_o); end
        tick();
        vectors++; if (spr_picsr_o !== 32'h20) begin miscompares++; $display("FAIL lvl_picsr_t2: got %h want 20", spr_picsr_o); end
        vectors++; if (irq_o !== 1'b0) begin miscompares++; $display("FAIL lvl_irq_t2: got %b want 0", irq_o); end
        tick();
        vectors++; if (irq_o !== 1'b1 || irq_id_o !== 5'd5) begin miscompares++; $display("FAIL lvl_req_t3: got irq=%b id=%0d want 1/5", irq_o, irq_id_o); end
        irq_ack_i = 1'b1;
        tick();
        vectors++; if (irq_o !== 1'b0) begin miscompares++; $display("FAIL lvl_hold: got %b want 0", irq_o); end
        tick();
        vectors++; if (irq_o !== 1'b0) begin miscompares++; $display("FAIL lvl_gap2: got %b want 0", irq_o); end
        tick();
        vectors++; if (irq_o !== 1'b1 || irq_id_o !== 5'd5) begin miscompares++; $display("FAIL lvl_rereq: got irq=%b id=%0d want 1/5", irq_o, irq_id_o); end
        irq_i = 8'h00;
        tick();
        tick();
        vectors++; if (spr_picsr_o !== 32'h0 || irq_o !== 1'b1) begin miscompares++; $display("FAIL lvl_drop: got picsr=%h irq=%b want 0/1", spr_picsr_o, irq_o); end
        tick();
        vectors++; if (irq_o !== 1'b0) begin miscompares++; $display("FAIL lvl_withdraw: got %b want 0", irq_o); end
    endtask

    task automatic test_edge_ack();
        do_reset();
        spr_wr(A_PICMR, 32'hFF);
        spr_wr(A_PICTR, 32'h08);
        irq_i = 8'h08;
        tick();
        irq_i = 8'h00;
        tick();
        vectors++; if (spr_picsr_o !== 32'h0) begin miscompares++; $display("FAIL edge_picsr_t2: got %h want 0", spr_picsr_o); end
        tick();
        vectors++; if (spr_picsr_o !== 32'h08) begin miscompares++; $display("FAIL edge_picsr_t3: got %h want 08", spr_picsr_o); end
        tick();
        vectors++; if (irq_o !== 1'b1 || irq_id_o !== 5'd3 || spr_picsr_o !== 32'h08) begin miscompares++; $display("FAIL edge_req: got irq=%b id=%0d picsr=%h want 1/3/08", irq_o, irq_id_o, spr_picsr_o); end
        irq_ack_i = 1'b1;
        tick();
        vectors++; if (spr_picsr_o !== 32'h0 || irq_o !== 1'b0) begin miscompares++; $display("FAIL edge_ack: got picsr=%h irq=%b want 0/0", spr_picsr_o, irq_o); end
        tick();
        tick();
        vectors++; if (irq_o !== 1'b0) begin miscompares++; $display("FAIL edge_idle: got %b want 0", irq_o); end
    endtask

    task automatic test_withdraw();
        do_reset();
        spr_wr(A_PICMR, 32'hFF);
        irq_i = 8'h24;
        repeat (3) tick();
        vectors++; if (irq_o !== 1'b1 || irq_id_o !== 5'd2) begin miscompares++; $display("FAIL wd_req: got irq=%b id=%0d want 1/2", irq_o, irq_id_o); end
        spr_wr(A_PICMR, 32'hF8);
        vectors++; if (spr_picsr_o !== 32'h20 || irq_o !== 1'b1) begin miscompares++; $display("FAIL wd_mask: got picsr=%h irq=%b want 20/1", spr_picsr_o, irq_o); end
        tick();
        vectors++; if (irq_o !== 1'b0) begin miscompares++; $display("FAIL wd_drop: got %b want 0", irq_o); end
        tick();
        vectors++; if (irq_o !== 1'b1 || irq_id_o !== 5'd5) begin miscompares++; $display("FAIL wd_next: got irq=%b id=%0d want 1/5", irq_o, irq_id_o); end
    endtask

    task automatic test_set_beats_clear();
        do_reset();
        spr_wr(A_PICMR, 32'hFF);
        spr_wr(A_PICTR, 32'h02);
        irq_i = 8'h02;
        tick();
        tick();
        spr_wr(A_PICSR, 32'h02);
        vectors++; if (spr_picsr_o !== 32'h02) begin miscompares++; $display("FAIL sbc_picsr: got %h want 02", spr_picsr_o); end
        tick();
        vectors++; if (irq_o !== 1'b1 || irq_id_o !== 5'd1) begin miscompares++; $display("FAIL sbc_req: got irq=%b id=%0d want 1/1", irq_o, irq_id_o); end
        spr_wr(A_PICSR, 32'h02);
        vectors++; if (spr_picsr_o !== 32'h0) begin miscompares++; $display("FAIL sbc_sprclr: got %h want 0", spr_picsr_o); end
        tick();
        vectors++; if (irq_o !== 1'b0) begin miscompares++; $display("FAIL sbc_withdraw: got %b want 0", irq_o); end
    endtask

    task automatic test_nmi_spr();
        do_reset();
        spr_wr(A_PICMR, 32'h0);
        spr_access_i = 1'b1; spr_we_i = 1'b0; spr_addr_i = A_PICMR; #1;
        vectors++; if (spr_dat_o !== 32'h3) begin miscompares++; $display("FAIL nmi_rd_picmr: got %h want 3", spr_dat_o); end
        spr_addr_i = A_OFS1; #1;
        vectors++; if (spr_dat_o !== 32'h0) begin miscompares++; $display("FAIL nmi_rd_ofs1: got %h want 0", spr_dat_o); end
        spr_access_i = 1'b0;
        irq_i = 8'h01;
        tick();
        tick();
        vectors++; if (spr_picsr_o !== 32'h1) begin miscompares++; $display("FAIL nmi_level: got %h want 1", spr_picsr_o); end
        spr_wr(A_PICSR, 32'h1);
        vectors++; if (spr_picsr_o !== 32'h1) begin miscompares++; $display("FAIL nmi_lvl_wr: got %h want 1", spr_picsr_o); end
        spr_access_i = 1'b1; spr_we_i = 1'b0; spr_addr_i = A_PICSR; #1;
        vectors++; if (spr_dat_o !== 32'h1) begin miscompares++; $display("FAIL nmi_rd_picsr: got %h want 1", spr_dat_o); end
        tick();
    endtask

    task automatic test_async_reset();
        do_reset();
        irq_i = 8'h01;
        repeat (3) tick();
        vectors++; if (irq_o !== 1'b1) begin miscompares++; $display("FAIL ar_pre: got %b want 1", irq_o); end
        #2 rst = 1'b1;
        #1;
        vectors++; if (irq_o !== 1'b0 || spr_picsr_o !== 32'h0 || spr_picmr_o !== 32'h3) begin miscompares++; $display("FAIL ar_async: got irq=%b picsr=%h picmr=%h want 0/0/3", irq_o, spr_picsr_o, spr_picmr_o); end
        m_reset();
        irq_i = 8'h00;
        #3 rst = 1'b0;
        repeat (4) tick();
        vectors++; if (irq_o !== 1'b0) begin miscompares++; $display("FAIL ar_quiet: got %b want 0", irq_o); end
        irq_i = 8'h01;
        repeat (3) tick();
        vectors++; if (irq_o !== 1'b1 || irq_id_o !== 5'd0) begin miscompares++; $display("FAIL ar_newreq: got irq=%b id=%0d want 1/0", irq_o, irq_id_o); end
    endtask

    task automatic test_random();
        logic [7:0] ps;
        do_reset();
        for (int n = 0; n < 600; n++) begin
            irq_i = irq_i ^ 8'($urandom & $urandom & $urandom);
            if ($urandom_range(0, 4) == 0) begin
                spr_access_i = 1'b1;
                spr_we_i     = 1'($urandom_range(0, 1));
                spr_addr_i   = A_PICMR + 16'($urandom_range(0, 4));
                spr_dat_i    = $urandom;
            end
            irq_ack_i = ($urandom_range(0, 2) == 0);
            #1;
            ps = m_picsr();
            vectors++; if (spr_picsr_o !== {24'd0, ps}) begin miscompares++; $display("FAIL rnd_picsr @%0d: got %h want %h", n, spr_picsr_o, ps); end
            vectors++; if (spr_picmr_o !== {24'd0, m_mask}) begin miscompares++; $display("FAIL rnd_picmr @%0d: got %h want %h", n, spr_picmr_o, m_mask); end
            vectors++; if (spr_dat_o !== m_rd()) begin miscompares++; $display("FAIL rnd_rd @%0d: got %h want %h", n, spr_dat_o, m_rd()); end
            vectors++; if (irq_o !== m_req) begin miscompares++; $display("FAIL rnd_irq @%0d: got %b want %b", n, irq_o, m_req); end
            if (m_req) begin
                vectors++; if (irq_id_o !== 5'(m_id)) begin miscompares++; $display("FAIL rnd_id @%0d: got %0d want %0d", n, irq_id_o, m_id); end
            end
            tick();
        end
    endtask

    initial begin
        test_reset();
        test_level_basic();
        test_edge_ack();
        test_withdraw();
        test_set_beats_clear();
        test_nmi_spr();
        test_async_reset();
        test_random();
        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end

endmodule
